// File: rtl/nmix_pkg.sv
// Shared definitions for the NMIX MAC engine: FSM encoding, counter width
// and a width-generic rotate-left helper.
package nmix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_MIX    = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

    // Widest W the rotate helper handles; callers zero-extend into this width.
    localparam int MAX_W = 128;

    // Rotate the low w bits of v left by amt (amt < w); bits above w are zero.
    function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] v,
                                              input int amt,
                                              input int w);
        logic [MAX_W-1:0] mask;
        mask = (w >= MAX_W) ? {MAX_W{1'b1}} : ((MAX_W'(1) << w) - MAX_W'(1));
        return ((v << amt) | (v >> (w - amt))) & mask;
    endfunction

endpackage

// File: rtl/nmix_core.sv
// Combinational NMIX mixer: a ripple of XOR/AND carries across W bits,
// with the final carry-out dropped.
module nmix_core #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_r,
    output logic [W-1:0] o_y
);

    logic w_c;

    // Bit-serial carry chain from LSB to MSB
    always_comb begin
        o_y = '0;
        w_c = 1'b0;
        for (int i = 0; i < W; i++) begin
            o_y[i] = i_x[i] ^ i_r[i] ^ w_c;
            w_c    = (i_x[i] & i_r[i]) ^ w_c;
        end
    end

endmodule

// File: rtl/nmix_mac.sv
// Sequential MAC engine: absorbs W-bit words under a captured key, running
// ROUNDS NMIX rounds per word, then holds the tag until acknowledged.
module nmix_mac
    import nmix_pkg::*;
#(
    parameter int          W      = 32,
    parameter int          ROUNDS = 4,
    parameter logic [W-1:0] IV    = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [W-1:0]     key,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             tag_valid,
    output logic [W-1:0]     tag,
    input  logic             tag_ack,
    output logic             busy,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int RW = $clog2(ROUNDS + 1);
    localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [W-1:0]     r_s;
    logic [W-1:0]     r_key;
    logic [RW-1:0]    r_round;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last;
    logic [W-1:0]     w_round_key;
    logic [W-1:0]     w_mix_y;
    logic             w_last_round;

    // Round r mixes with the key rotated left by r mod W.
    assign w_round_key  = W'(rotl(MAX_W'(r_key), int'(r_round) % W, W));
    assign w_last_round = (r_round == LAST_ROUND);
    assign word_cnt     = r_cnt;

    nmix_core #(.W(W)) u_core (
        .i_x (r_s),
        .i_r (w_round_key),
        .o_y (w_mix_y)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and outputs decoded from registered state only
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        tag_valid    = 1'b0;
        tag          = '0;
        busy         = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) w_state_next = ST_ACCEPT;
                else       w_state_next = ST_IDLE;
            end
            ST_ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = ST_MIX;
                else          w_state_next = ST_ACCEPT;
            end
            ST_MIX: begin
                if (w_last_round) w_state_next = r_last ? ST_DONE : ST_ACCEPT;
                else              w_state_next = ST_MIX;
            end
            ST_DONE: begin
                tag_valid = 1'b1;
                tag       = r_s;
                if (tag_ack) w_state_next = ST_IDLE;
                else         w_state_next = ST_DONE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: state, key, round index, word count and last flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s     <= '0;
            r_key   <= '0;
            r_round <= '0;
            r_cnt   <= '0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_s   <= IV;
                        r_key <= key;
                        r_cnt <= '0;
                    end
                end
                ST_ACCEPT: begin
                    if (in_valid) begin
                        r_s     <= r_s ^ in_data;
                        r_last  <= in_last;
                        r_round <= '0;
                        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_MIX: begin
                    r_s     <= w_mix_y;
                    r_round <= r_round + RW'(1);
                end
                default: begin
                    r_s <= r_s;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nmix_mac.sv
// Scoreboard bench for nmix_mac: three instances (W=32/R=1, W=32/R=4/IV, W=8/R=1).
module tb_nmix_mac;

    typedef struct {
        logic [31:0] tag;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic a_start, a_in_valid, a_in_last, a_tag_ack, a_in_ready, a_tag_valid, a_busy;
    logic [31:0] a_key, a_in_data, a_tag;
    logic [15:0] a_cnt;
    logic b_start, b_in_valid, b_in_last, b_tag_ack, b_in_ready, b_tag_valid, b_busy;
    logic [31:0] b_key, b_in_data, b_tag;
    logic [15:0] b_cnt;
    logic c_start, c_in_valid, c_in_last, c_tag_ack, c_in_ready, c_tag_valid, c_busy;
    logic [7:0] c_key, c_in_data, c_tag;
    logic [15:0] c_cnt;

    nmix_mac #(.W(32), .ROUNDS(1), .IV(32'h0)) u_a (
        .clk(clk), .reset(reset), .start(a_start), .key(a_key),
        .in_valid(a_in_valid), .in_data(a_in_data), .in_last(a_in_last),
        .in_ready(a_in_ready), .tag_valid(a_tag_valid), .tag(a_tag),
        .tag_ack(a_tag_ack), .busy(a_busy), .word_cnt(a_cnt));

    nmix_mac #(.W(32), .ROUNDS(4), .IV(32'hA5A5A5A5)) u_b (
        .clk(clk), .reset(reset), .start(b_start), .key(b_key),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_last(b_in_last),
        .in_ready(b_in_ready), .tag_valid(b_tag_valid), .tag(b_tag),
        .tag_ack(b_tag_ack), .busy(b_busy), .word_cnt(b_cnt));

    nmix_mac #(.W(8), .ROUNDS(1), .IV(8'h00)) u_c (
        .clk(clk), .reset(reset), .start(c_start), .key(c_key),
        .in_valid(c_in_valid), .in_data(c_in_data), .in_last(c_in_last),
        .in_ready(c_in_ready), .tag_valid(c_tag_valid), .tag(c_tag),
        .tag_ack(c_tag_ack), .busy(c_busy), .word_cnt(c_cnt));

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    logic pa = 1'b0;
    logic pb = 1'b0;
    logic pc = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: pop the expected tag on each rising tag_valid
    always @(negedge clk) begin
        pa <= a_tag_valid;
        if (a_tag_valid && !pa) begin
            if (q_a.size() == 0) chk("a_spurious_tag", {32'h0, a_tag}, 64'h0);
            else begin
                chk("a_tag", {32'h0, a_tag}, {32'h0, q_a[0].tag});
                chk("a_word_cnt", {48'h0, a_cnt}, {48'h0, q_a[0].cnt});
                void'(q_a.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        pb <= b_tag_valid;
        if (b_tag_valid && !pb) begin
            if (q_b.size() == 0) chk("b_spurious_tag", {32'h0, b_tag}, 64'h0);
            else begin
                chk("b_tag", {32'h0, b_tag}, {32'h0, q_b[0].tag});
                chk("b_word_cnt", {48'h0, b_cnt}, {48'h0, q_b[0].cnt});
                void'(q_b.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        pc <= c_tag_valid;
        if (c_tag_valid && !pc) begin
            if (q_c.size() == 0) chk("c_spurious_tag", {56'h0, c_tag}, 64'h0);
            else begin
                chk("c_tag", {56'h0, c_tag}, {32'h0, q_c[0].tag});
                chk("c_word_cnt", {48'h0, c_cnt}, {48'h0, q_c[0].cnt});
                void'(q_c.pop_front());
            end
        end
    end

    task automatic a_send(input logic [31:0] d, input logic l);
        int k = 0;
        a_in_valid = 1'b1; a_in_data = d; a_in_last = l;
        while (a_in_ready !== 1'b1 && k < 40) begin tick(); k++; end
        chk("a_in_ready_wait", {63'h0, a_in_ready}, 64'h1);
        tick();
        a_in_valid = 1'b0; a_in_last = 1'b0;
    endtask

    task automatic b_send(input logic [31:0] d, input logic l);
        int k = 0;
        b_in_valid = 1'b1; b_in_data = d; b_in_last = l;
        while (b_in_ready !== 1'b1 && k < 40) begin tick(); k++; end
        chk("b_in_ready_wait", {63'h0, b_in_ready}, 64'h1);
        tick();
        b_in_valid = 1'b0; b_in_last = 1'b0;
    endtask

    task automatic a_finish();
        int k = 0;
        while (a_tag_valid !== 1'b1 && k < 40) begin tick(); k++; end
        chk("a_tag_valid_wait", {63'h0, a_tag_valid}, 64'h1);
        a_tag_ack = 1'b1; tick(); a_tag_ack = 1'b0;
    endtask

    task automatic b_finish();
        int k = 0;
        while (b_tag_valid !== 1'b1 && k < 40) begin tick(); k++; end
        chk("b_tag_valid_wait", {63'h0, b_tag_valid}, 64'h1);
        b_tag_ack = 1'b1; tick(); b_tag_ack = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tagname);
        chk({tagname, "_a_ready"},  {63'h0, a_in_ready},  64'h0);
        chk({tagname, "_a_valid"},  {63'h0, a_tag_valid}, 64'h0);
        chk({tagname, "_a_tag"},    {32'h0, a_tag},       64'h0);
        chk({tagname, "_a_busy"},   {63'h0, a_busy},      64'h0);
        chk({tagname, "_a_cnt"},    {48'h0, a_cnt},       64'h0);
        chk({tagname, "_b_busy"},   {63'h0, b_busy},      64'h0);
        chk({tagname, "_b_tag"},    {32'h0, b_tag},       64'h0);
        chk({tagname, "_c_busy"},   {63'h0, c_busy},      64'h0);
        chk({tagname, "_c_tag"},    {56'h0, c_tag},       64'h0);
    endtask

    initial begin
        {a_start, a_in_valid, a_in_last, a_tag_ack} = 4'b0;
        {b_start, b_in_valid, b_in_last, b_tag_ack} = 4'b0;
        {c_start, c_in_valid, c_in_last, c_tag_ack} = 4'b0;
        a_key = 32'h0; a_in_data = 32'h0;
        b_key = 32'h0; b_in_data = 32'h0;
        c_key = 8'h0;  c_in_data = 8'h0;

        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk_reset_outputs("rst");

        // A: single word, one round; key changes after capture must not matter
        a_start = 1'b1; a_key = 32'h1;
        tick();
        a_start = 1'b0; a_key = 32'hDEADBEEF;
        chk("a_start_to_ready", {63'h0, a_in_ready}, 64'h1);
        q_a.push_back('{tag: 32'hFFFFFFFE, cnt: 16'd1});
        a_send(32'h1, 1'b1);
        chk("a_mix_ready_low", {63'h0, a_in_ready}, 64'h0);
        chk("a_mix_valid_low", {63'h0, a_tag_valid}, 64'h0);
        tick();
        chk("a_latency1_valid", {63'h0, a_tag_valid}, 64'h1);

        // A: stall in DONE with ignored start pulses
        for (int i = 0; i < 10; i++) begin
            a_start = (i % 2 == 0);
            tick();
            chk("a_stall_valid", {63'h0, a_tag_valid}, 64'h1);
            chk("a_stall_tag", {32'h0, a_tag}, 64'h00000000FFFFFFFE);
        end
        a_start = 1'b0;
        a_tag_ack = 1'b1;
        tick();
        a_tag_ack = 1'b0;
        chk("a_ack_idle_busy", {63'h0, a_busy}, 64'h0);
        chk("a_ack_idle_valid", {63'h0, a_tag_valid}, 64'h0);
        chk("a_ack_idle_tag", {32'h0, a_tag}, 64'h0);
        chk("a_idle_cnt_hold", {48'h0, a_cnt}, 64'h1);

        // A: back-to-back start; NMIX(1,3) = 0xFFFFFFFC
        a_start = 1'b1; a_key = 32'h3;
        tick();
        a_start = 1'b0;
        chk("a_b2b_ready", {63'h0, a_in_ready}, 64'h1);
        chk("a_b2b_cnt_clear", {48'h0, a_cnt}, 64'h0);
        q_a.push_back('{tag: 32'hFFFFFFFC, cnt: 16'd1});
        a_send(32'h1, 1'b1);
        a_finish();

        // B: round timing with key=0 (identity), tag = IV ^ 0xF
        b_start = 1'b1; b_key = 32'h0;
        tick();
        b_start = 1'b0;
        q_b.push_back('{tag: 32'hA5A5A5AA, cnt: 16'd1});
        b_send(32'h0000000F, 1'b1);
        chk("b_r0_ready", {63'h0, b_in_ready}, 64'h0);
        chk("b_r0_valid", {63'h0, b_tag_valid}, 64'h0);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("b_mix_ready", {63'h0, b_in_ready}, 64'h0);
            chk("b_mix_valid", {63'h0, b_tag_valid}, 64'h0);
        end
        tick();
        chk("b_latency4_valid", {63'h0, b_tag_valid}, 64'h1);
        b_tag_ack = 1'b1; tick(); b_tag_ack = 1'b0;

        // B: multi-word chaining, tag = A5A5A5A5 ^ 0000FFFF ^ FFFF0000
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        q_b.push_back('{tag: 32'h5A5A5A5A, cnt: 16'd2});
        b_send(32'h0000FFFF, 1'b0);
        chk("b_gap_ready0", {63'h0, b_in_ready}, 64'h0);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("b_gap_ready", {63'h0, b_in_ready}, 64'h0);
        end
        tick();
        chk("b_gap_ready_back", {63'h0, b_in_ready}, 64'h1);
        b_send(32'hFFFF0000, 1'b1);
        b_finish();

        // B: rotated round keys 0x80000000,1,2,4 on S=0 give 0x80000007
        b_start = 1'b1; b_key = 32'h80000000;
        tick();
        b_start = 1'b0;
        q_b.push_back('{tag: 32'h80000007, cnt: 16'd1});
        b_send(32'hA5A5A5A5, 1'b1);
        b_finish();

        // C: 8-bit width
        c_start = 1'b1; c_key = 8'h01;
        tick();
        c_start = 1'b0;
        q_c.push_back('{tag: 32'h000000FE, cnt: 16'd1});
        c_in_valid = 1'b1; c_in_data = 8'h01; c_in_last = 1'b1;
        chk("c_ready", {63'h0, c_in_ready}, 64'h1);
        tick();
        c_in_valid = 1'b0; c_in_last = 1'b0;
        tick();
        chk("c_valid", {63'h0, c_tag_valid}, 64'h1);
        c_tag_ack = 1'b1; tick(); c_tag_ack = 1'b0;

        // A: reset during MIX of word 2, then a fresh message
        a_start = 1'b1; a_key = 32'h1;
        tick();
        a_start = 1'b0;
        a_send(32'h5, 1'b0);
        a_send(32'h1, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_outputs("midrst");
        tick(); tick();
        chk("a_no_tag_after_rst", {63'h0, a_tag_valid}, 64'h0);
        a_start = 1'b1; a_key = 32'h1;
        tick();
        a_start = 1'b0;
        q_a.push_back('{tag: 32'hFFFFFFFE, cnt: 16'd1});
        a_send(32'h1, 1'b1);
        a_finish();

        tick(); tick();
        chk("q_a_drained", 64'(q_a.size()), 64'h0);
        chk("q_b_drained", 64'(q_b.size()), 64'h0);
        chk("q_c_drained", 64'(q_c.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
